// File: rtl/input_debounce_capture_pkg.sv
// Shared types and helpers for the push-button / slide-switch input conditioning path.
package input_pkg;

    typedef enum logic {STABLE, PENDING} debounce_state_t;

    localparam int SYNC_STAGES = 2;

    // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits are enough.
    function automatic int counter_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/input_debounce_capture_debounce_cell.sv
// One input bit: 2-flop synchroniser, optional inversion, STABLE/PENDING debounce FSM.
// rise_o is high in the cycle before level_o goes 0->1, so a consumer registering it lands on the same edge.
module debounce_cell
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    debounce_state_t        state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   sample;
    logic                   differs;

    // Reset the synchroniser to the pin's idle level so release of reset is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INVERT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sample  = sync_q[SYNC_STAGES-1] ^ INVERT;
    assign differs = (sample != level_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state_q)
                STABLE: begin
                    if (differs) begin
                        state_q <= PENDING;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                PENDING: begin
                    if (!differs) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST_COUNT) begin
                        level_q <= ~level_q;
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = (state_q == PENDING) && differs && (cnt_q == LAST_COUNT) && !level_q;

endmodule

// File: rtl/input_debounce_capture.sv
// Debounced button/switch levels, sticky press-capture bits with write-one-to-clear,
// and a maskable registered interrupt request.
module input_debounce_capture
    import input_pkg::*;
#(
    parameter int N_BUTTONS       = 1,
    parameter int N_SWITCHES      = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BUTTONS-1:0]  button_raw,
    input  logic [N_SWITCHES-1:0] switch_raw,
    output logic [N_BUTTONS-1:0]  button_level,
    output logic [N_SWITCHES-1:0] switch_level,
    output logic [N_BUTTONS-1:0]  press_capture,
    input  logic                  clear_valid,
    input  logic [N_BUTTONS-1:0]  clear_mask,
    input  logic [N_BUTTONS-1:0]  irq_mask,
    output logic                  irq
);

    logic [N_BUTTONS-1:0]  button_rise;
    logic [N_SWITCHES-1:0] unused_switch_rise;
    logic [N_BUTTONS-1:0]  capture_q;
    logic [N_BUTTONS-1:0]  capture_d;
    logic [N_BUTTONS-1:0]  clear_bits;
    logic                  irq_q;
    logic                  irq_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_BUTTONS; gi++) begin : g_button
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .INVERT         (1'b1)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .raw_i  (button_raw[gi]),
                .level_o(button_level[gi]),
                .rise_o (button_rise[gi])
            );
        end
        for (gi = 0; gi < N_SWITCHES; gi++) begin : g_switch
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .INVERT         (1'b0)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .raw_i  (switch_raw[gi]),
                .level_o(switch_level[gi]),
                .rise_o (unused_switch_rise[gi])
            );
        end
    endgenerate

    // A press landing on the same edge as its clear keeps the bit set.
    always_comb begin
        clear_bits = clear_valid ? clear_mask : '0;
        capture_d  = (capture_q & ~clear_bits) | button_rise;
        irq_d      = |(capture_q & irq_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capture_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            capture_q <= capture_d;
            irq_q     <= irq_d;
        end
    end

    assign press_capture = capture_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_input_debounce_capture.sv
// Directed bench for input_debounce_capture with DEBOUNCE_CYCLES = 8, two buttons, two switches.
module tb_input_debounce_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] button_raw = 2'b11;
    logic [1:0] switch_raw = 2'b00;
    logic [1:0] button_level;
    logic [1:0] switch_level;
    logic [1:0] press_capture;
    logic       clear_valid = 1'b0;
    logic [1:0] clear_mask = 2'b00;
    logic [1:0] irq_mask = 2'b11;
    logic       irq;

    int tests_run    = 0;
    int tests_failed = 0;

    input_debounce_capture #(
        .N_BUTTONS      (2),
        .N_SWITCHES     (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button_raw   (button_raw),
        .switch_raw   (switch_raw),
        .button_level (button_level),
        .switch_level (switch_level),
        .press_capture(press_capture),
        .clear_valid  (clear_valid),
        .clear_mask   (clear_mask),
        .irq_mask     (irq_mask),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({button_level, switch_level, press_capture, irq} !== 7'b0) begin
            $display("FAIL reset_outputs: got %b required %b", {button_level, switch_level, press_capture, irq}, 7'b0);
            tests_failed++;
        end
        rst = 1'b0;
        repeat (4) tick();
        tests_run++;
        if ({button_level, switch_level, press_capture, irq} !== 7'b0) begin
            $display("FAIL post_reset_idle: got %b required %b", {button_level, switch_level, press_capture, irq}, 7'b0);
            tests_failed++;
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_press();
        button_raw[0] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            tests_run++;
            if (button_level[0] !== (c >= 10)) begin
                $display("FAIL clean_level c=%0d: got %b required %b", c, button_level[0], (c >= 10));
                tests_failed++;
            end
            if (c == 10) begin
                tests_run++;
                if (press_capture !== 2'b01 || irq !== 1'b0) begin
                    $display("FAIL clean_capture: got cap=%b irq=%b required cap=01 irq=0", press_capture, irq);
                    tests_failed++;
                end
            end
            if (c == 11) begin
                tests_run++;
                if (irq !== 1'b1) begin
                    $display("FAIL clean_irq: got %b required 1", irq);
                    tests_failed++;
                end
            end
        end
        button_raw[0] = 1'b1;
        repeat (12) tick();
        tests_run++;
        if (button_level[0] !== 1'b0 || press_capture !== 2'b01) begin
            $display("FAIL release_no_event: got lvl=%b cap=%b required lvl=0 cap=01", button_level[0], press_capture);
            tests_failed++;
        end
        clear_valid = 1'b1;
        clear_mask  = 2'b01;
        tick();
        clear_valid = 1'b0;
        clear_mask  = 2'b00;
        tests_run++;
        if (press_capture !== 2'b00) begin
            $display("FAIL w1c_clear: got %b required 00", press_capture);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_after_clear: got %b required 0", irq);
            tests_failed++;
        end
        $display("[TB] test_clean_press done");
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 10; k++) begin
            button_raw[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) begin
                tick();
                tests_run++;
                if (button_level[1] !== 1'b0) begin
                    $display("FAIL bounce_level k=%0d: got %b required 0", k, button_level[1]);
                    tests_failed++;
                end
            end
        end
        button_raw[1] = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            tests_run++;
            if (button_level[1] !== (c >= 10)) begin
                $display("FAIL bounce_settle c=%0d: got %b required %b", c, button_level[1], (c >= 10));
                tests_failed++;
            end
            if (c == 10 || c == 15) begin
                tests_run++;
                if (press_capture !== 2'b10) begin
                    $display("FAIL bounce_capture c=%0d: got %b required 10", c, press_capture);
                    tests_failed++;
                end
            end
        end
        tests_run++;
        if (irq !== 1'b1) begin
            $display("FAIL bounce_irq: got %b required 1", irq);
            tests_failed++;
        end
        $display("[TB] test_bounce done");
    endtask

    task automatic test_glitch();
        clear_valid = 1'b1;
        clear_mask  = 2'b11;
        tick();
        clear_valid = 1'b0;
        clear_mask  = 2'b00;
        tick();
        switch_raw[0] = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c == 7) switch_raw[0] = 1'b0;
            tests_run++;
            if (switch_level !== 2'b00) begin
                $display("FAIL glitch_level c=%0d: got %b required 00", c, switch_level);
                tests_failed++;
            end
        end
        switch_raw[1] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 8) switch_raw[1] = 1'b0;
            tests_run++;
            if (switch_level[1] !== (c >= 10 && c < 18)) begin
                $display("FAIL switch_min_pulse c=%0d: got %b required %b", c, switch_level[1], (c >= 10 && c < 18));
                tests_failed++;
            end
        end
        tests_run++;
        if (press_capture !== 2'b00 || irq !== 1'b0) begin
            $display("FAIL switch_no_event: got cap=%b irq=%b required cap=00 irq=0", press_capture, irq);
            tests_failed++;
        end
        $display("[TB] test_glitch done");
    endtask

    task automatic test_clear_collision();
        button_raw[1] = 1'b1;
        repeat (12) tick();
        button_raw[1] = 1'b0;
        repeat (10) tick();
        button_raw[0] = 1'b0;
        repeat (10) tick();
        tests_run++;
        if (press_capture !== 2'b11) begin
            $display("FAIL collision_setup: got %b required 11", press_capture);
            tests_failed++;
        end
        button_raw[0] = 1'b1;
        repeat (12) tick();
        button_raw[0] = 1'b0;
        repeat (9) tick();
        clear_valid = 1'b1;
        clear_mask  = 2'b11;
        tick();
        clear_valid = 1'b0;
        clear_mask  = 2'b00;
        tests_run++;
        if (button_level[0] !== 1'b1 || press_capture !== 2'b01) begin
            $display("FAIL collision_set_wins: got lvl=%b cap=%b required lvl=1 cap=01", button_level[0], press_capture);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (irq !== 1'b1) begin
            $display("FAIL collision_irq: got %b required 1", irq);
            tests_failed++;
        end
        clear_mask = 2'b11;
        tick();
        clear_mask = 2'b00;
        tests_run++;
        if (press_capture !== 2'b01) begin
            $display("FAIL mask_without_valid: got %b required 01", press_capture);
            tests_failed++;
        end
        $display("[TB] test_clear_collision done");
    endtask

    task automatic test_irq_mask();
        button_raw[1] = 1'b1;
        repeat (12) tick();
        button_raw[1] = 1'b0;
        repeat (10) tick();
        clear_valid = 1'b1;
        clear_mask  = 2'b01;
        irq_mask    = 2'b01;
        tick();
        clear_valid = 1'b0;
        clear_mask  = 2'b00;
        tests_run++;
        if (press_capture !== 2'b10) begin
            $display("FAIL clear_independent: got %b required 10", press_capture);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_masked: got %b required 0", irq);
            tests_failed++;
        end
        irq_mask = 2'b10;
        #1;
        tests_run++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_mask_latency: got %b required 0", irq);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (irq !== 1'b1) begin
            $display("FAIL irq_unmasked: got %b required 1", irq);
            tests_failed++;
        end
        $display("[TB] test_irq_mask done");
    endtask

    task automatic test_reset_mid_debounce();
        button_raw = 2'b11;
        repeat (12) tick();
        tests_run++;
        if (button_level !== 2'b00 || irq !== 1'b1) begin
            $display("FAIL pre_reset_state: got lvl=%b irq=%b required lvl=00 irq=1", button_level, irq);
            tests_failed++;
        end
        button_raw[0] = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({button_level, switch_level, press_capture, irq} !== 7'b0) begin
            $display("FAIL async_reset: got %b required %b", {button_level, switch_level, press_capture, irq}, 7'b0);
            tests_failed++;
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            tests_run++;
            if (button_level[0] !== (c >= 10)) begin
                $display("FAIL held_through_reset c=%0d: got %b required %b", c, button_level[0], (c >= 10));
                tests_failed++;
            end
            if (c == 10) begin
                tests_run++;
                if (press_capture !== 2'b01) begin
                    $display("FAIL held_capture: got %b required 01", press_capture);
                    tests_failed++;
                end
            end
        end
        $display("[TB] test_reset_mid_debounce done");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_clear_collision();
        test_irq_mask();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
